// File: rtl/mod_pkg.sv
// Shared constants and compile-time helpers for the modular reduction datapath.
// Barrett shift/multiplier derivation lives here so every reducer agrees on it.
package mod_pkg;

    localparam logic MODE_CENTRED = 1'b0;
    localparam logic MODE_POS     = 1'b1;

    // Shift amount: wide enough that the quotient estimate is off by at most one.
    function automatic int barrett_k(input int in_w, input int q);
        return in_w + $clog2(q);
    endfunction

    // Reciprocal constant floor(2^K / Q); computed wide since K may reach 64.
    function automatic logic [63:0] barrett_m(input int k, input int q);
        logic [127:0] num;
        logic [127:0] den;
        logic [127:0] quo;
        num = 128'd1 << k;
        den = {96'd0, q};
        quo = num / den;
        return quo[63:0];
    endfunction

endpackage

// File: rtl/mod_pipe_stage.sv
// Enable-gated register slice with asynchronous active-low clear.
// Carries one whole pipeline stage bundle (valid, sideband and data).
module mod_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load on enable, otherwise hold; reset clears the slice immediately.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mod_reduce_pipe.sv
// Three-stage pipelined signed Barrett reducer with valid/ready handshake.
// Stage 1 multiplies by the reciprocal, stage 2 forms the partial residue, stage 3 corrects.
module mod_reduce_pipe
    import mod_pkg::*;
#(
    parameter int Q     = 7177,
    parameter int IN_W  = 35,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  In,
    input  logic                    in_mode,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [$clog2(Q):0] Out,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int OUT_W = $clog2(Q) + 1;
    localparam int K     = barrett_k(IN_W, Q);
    localparam logic [63:0] M = barrett_m(K, Q);
    localparam int MW    = $clog2(M + 64'd1) + 1;
    localparam int PW    = IN_W + MW;
    localparam int RW    = OUT_W + 2;
    localparam int XW    = (IN_W > RW) ? IN_W : RW;
    localparam int PXW   = (PW > RW) ? PW : RW;

    localparam logic signed [MW-1:0] M_S    = MW'(M);
    localparam logic [RW-1:0]        Q_U    = RW'(Q);
    localparam logic signed [RW-1:0] Q_S    = RW'(Q);
    localparam logic signed [RW-1:0] HALF_S = RW'((Q - 1) / 2);

    typedef struct packed {
        logic                   valid;
        logic                   mode;
        logic [TAG_W-1:0]       tag;
        logic signed [IN_W-1:0] x;
        logic signed [PW-1:0]   p;
    } s1_t;

    typedef struct packed {
        logic                 valid;
        logic                 mode;
        logic [TAG_W-1:0]     tag;
        logic signed [RW-1:0] r;
    } s2_t;

    typedef struct packed {
        logic                    valid;
        logic [TAG_W-1:0]        tag;
        logic signed [OUT_W-1:0] res;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic en;

    logic signed [PW-1:0]  in_ext;
    logic signed [PW-1:0]  m_ext;
    logic signed [PXW-1:0] p_w;
    logic signed [XW-1:0]  x_w;
    logic [RW-1:0]         qh_lo;
    logic [RW-1:0]         qq;
    logic signed [RW-1:0]  r0;
    logic signed [RW-1:0]  r1;
    logic                  unused_bits;

    // The whole pipe advances together; a full pipe only stalls when output is held.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    assign in_ext = {{(PW-IN_W){In[IN_W-1]}}, In};
    assign m_ext  = {{(PW-MW){1'b0}}, M_S};

    // Stage 1: full-width product with the reciprocal, sideband captured per sample.
    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.mode  = in_mode;
        s1_d.tag   = in_tag;
        s1_d.x     = In;
        s1_d.p     = in_ext * m_ext;
    end

    mod_pipe_stage #(.W($bits(s1_t))) u_s1 (
        .clk   (clk),
        .Reset (Reset),
        .en    (en),
        .d     (s1_d),
        .q     (s1_q)
    );

    // Only the low RW bits of In - qh*Q matter: the true value lies in [0, 2Q).
    assign p_w   = PXW'($signed(s1_q.p) >>> K);
    assign x_w   = XW'($signed(s1_q.x));
    assign qh_lo = p_w[RW-1:0];
    assign qq    = qh_lo * Q_U;

    // Stage 2: partial residue from the floored quotient estimate.
    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.mode  = s1_q.mode;
        s2_d.tag   = s1_q.tag;
        s2_d.r     = x_w[RW-1:0] - qq;
    end

    mod_pipe_stage #(.W($bits(s2_t))) u_s2 (
        .clk   (clk),
        .Reset (Reset),
        .en    (en),
        .d     (s2_d),
        .q     (s2_q)
    );

    // Stage 3: fold into [0, Q), then into the centred range when requested.
    always_comb begin
        r0 = $signed(s2_q.r);
        r1 = r0;
        if (r1 >= Q_S) begin
            r1 = r1 - Q_S;
        end
        if ((s2_q.mode == MODE_CENTRED) && (r1 > HALF_S)) begin
            r1 = r1 - Q_S;
        end
        s3_d       = '0;
        s3_d.valid = s2_q.valid;
        s3_d.tag   = s2_q.tag;
        s3_d.res   = r1[OUT_W-1:0];
    end

    mod_pipe_stage #(.W($bits(s3_t))) u_s3 (
        .clk   (clk),
        .Reset (Reset),
        .en    (en),
        .d     (s3_d),
        .q     (s3_q)
    );

    assign out_valid = s3_q.valid;
    assign out_tag   = s3_q.tag;
    assign Out       = s3_q.res;

    // Bits discarded by the range argument are intentionally dropped here.
    assign unused_bits = ^{s1_q, p_w, x_w, r1};

endmodule

// File: tb/tb_mod_reduce_pipe.sv
// Scoreboard bench for mod_reduce_pipe (Q=7177, IN_W=35, TAG_W=4).
// Expected residues are pushed on accept and popped when the result is taken.
module tb_mod_reduce_pipe;

    localparam int  Q     = 7177;
    localparam int  IN_W  = 35;
    localparam int  TAG_W = 4;
    localparam int  OUT_W = 14;

    logic                    clk;
    logic                    Reset;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  In;
    logic                    in_mode;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] Out;
    logic [TAG_W-1:0]        out_tag;

    typedef struct {
        longint          v;
        logic [TAG_W-1:0] tag;
        int              stp;
    } exp_t;

    exp_t sbq[$];
    int   n_run;
    int   n_fail;
    int   stp;
    bit   lat_chk;

    mod_reduce_pipe #(.Q(Q), .IN_W(IN_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (step %0d)", name, got, exp, stp);
        end
    endtask

    function automatic longint model(input longint x, input bit mode);
        longint r;
        r = x % Q;
        if (r < 0) r = r + Q;
        if (!mode && r > (Q - 1) / 2) r = r - Q;
        return r;
    endfunction

    // One clock: drive, resolve transfers just before the edge, advance to negedge.
    task automatic step(input bit v, input longint x, input bit mode,
                        input logic [TAG_W-1:0] tag, input bit ordy,
                        input longint expv);
        exp_t e;
        in_valid  = v;
        In        = x[IN_W-1:0];
        in_mode   = mode;
        in_tag    = tag;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("out", Out, e.v);
                chk("tag", out_tag, e.tag);
                if (lat_chk) chk("latency", stp - e.stp, 3);
            end
        end
        if (in_valid && in_ready) begin
            e.v   = expv;
            e.tag = tag;
            e.stp = stp;
            sbq.push_back(e);
        end
        @(posedge clk);
        stp++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, '0, 1'b1, 0);
    endtask

    longint vals[6];
    longint exp0[6];
    longint exp1[6];
    bit     bub[5];
    logic [63:0] raw;
    logic signed [IN_W-1:0] s35;
    longint xr;
    bit     mr;

    initial begin
        n_run = 0; n_fail = 0; stp = 0; lat_chk = 1'b0;
        Reset = 1'b0; in_valid = 1'b0; In = '0; in_mode = 1'b0;
        in_tag = '0; out_ready = 1'b1;

        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", Out, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_in_ready", in_ready, 1);
        Reset = 1'b1;
        @(negedge clk);

        // Directed values and extremes, both modes, no stall.
        vals = '{0, 3589, -1, -64'sd17179869184, 64'sd17179869183, 7177};
        exp0 = '{0, -3588, -1, 2796, -2797, 0};
        exp1 = '{0, 3589, 7176, 2796, 4380, 0};
        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) step(1'b1, vals[i], 1'b0, TAG_W'(i), 1'b1, exp0[i]);
        for (int i = 0; i < 6; i++) step(1'b1, vals[i], 1'b1, TAG_W'(i + 8), 1'b1, exp1[i]);
        idle(4);
        chk("directed_drained", sbq.size(), 0);

        // Back-pressure: full pipe held for 5 clk, then drains in order.
        lat_chk = 1'b0;
        step(1'b1, 100, 1'b1, 4'd1, 1'b1, 100);
        step(1'b1, 200, 1'b1, 4'd2, 1'b1, 200);
        step(1'b1, 300, 1'b1, 4'd3, 1'b1, 300);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_tag = 4'd4; out_ready = 1'b0;
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_tag", out_tag, 1);
            chk("bp_out", Out, 100);
            step(1'b1, 400, 1'b1, 4'd4, 1'b0, 400);
        end
        for (int k = 1; k <= 3; k++) begin
            out_ready = 1'b1; in_valid = 1'b0;
            #1;
            chk("rel_out_valid", out_valid, 1);
            chk("rel_out_tag", out_tag, k);
            step(1'b0, 0, 1'b0, '0, 1'b1, 0);
        end
        idle(3);
        chk("bp_drained", sbq.size(), 0);

        // Bubbles propagate as empty slots with the same spacing.
        lat_chk = 1'b1;
        bub = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(bub[i], 1000 + i, 1'b0, TAG_W'(i + 5), 1'b1, model(1000 + i, 1'b0));
        end
        idle(4);
        chk("bubble_drained", sbq.size(), 0);

        // Asynchronous reset mid-cycle with samples in flight.
        lat_chk = 1'b0;
        step(1'b1, 11, 1'b1, 4'd11, 1'b1, 11);
        step(1'b1, 12, 1'b1, 4'd12, 1'b1, 12);
        step(1'b1, 13, 1'b1, 4'd13, 1'b1, 13);
        in_valid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out", Out, 0);
        chk("arst_out_tag", out_tag, 0);
        sbq.delete();
        #1;
        Reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("post_rst_idle", out_valid, 0);
            step(1'b0, 0, 1'b0, '0, 1'b1, 0);
        end

        // Random traffic with 70% downstream readiness.
        for (int i = 0; i < 3000; i++) begin
            raw = {$urandom(), $urandom()};
            s35 = raw[IN_W-1:0];
            xr  = s35;
            if (i % 97 == 0) xr = -64'sd17179869184;
            if (i % 89 == 0) xr = 64'sd17179869183;
            mr  = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 3) != 0), xr, mr, TAG_W'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7), model(xr, mr));
        end
        idle(6);
        chk("random_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
